// File: rtl/result_byte_tx.sv
// Result-frame consumer: captures NWORDS field elements over the return-to-zero
// handshake and streams them little-endian as bytes, optionally led by a header.
module result_byte_tx #(
   parameter int unsigned N      = 255,
   parameter int unsigned NWORDS = 2,
   parameter int unsigned HDR_EN = 1,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [N*NWORDS-1:0]   i_din,
   input  logic                  i_res_valid,
   output logic                  o_res_ready,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_tx_last,
   output logic                  o_busy,
   output logic [7:0]            o_frame_cnt
);

   localparam int unsigned BPW   = (N + 7) / 8;
   localparam int unsigned PW    = BPW * 8;
   localparam int unsigned SW    = NWORDS * PW;
   localparam int unsigned TOTAL = HDR_EN + NWORDS * BPW;
   localparam int unsigned CW    = $clog2(TOTAL + 1);
   localparam logic [CW-1:0] LastCnt = CW'(TOTAL - 1);

   typedef enum logic [1:0] {StIdle, StSend, StDrain} state_e;

   state_e          r_state;
   logic [SW-1:0]   r_shift;
   logic [CW-1:0]   r_cnt;
   logic            r_res_ready;
   logic [7:0]      r_tx_data;
   logic            r_tx_valid;
   logic            r_tx_last;
   logic [7:0]      r_frame_cnt;

   logic [SW-1:0]   w_pad;
   logic [SW-1:0]   w_shift_nxt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            w_hdr_slot;
   logic            w_accept;

   // Each word is zero-extended to a whole number of bytes.
   always_comb begin
      w_pad = '0;
      for (int w = 0; w < int'(NWORDS); w++) begin
         w_pad[w*PW +: N] = i_din[w*N +: N];
      end
   end

   // The header occupies slot 0 and must not consume payload bits.
   always_comb begin
      w_hdr_slot  = (HDR_EN != 0) && (r_cnt == '0);
      w_shift_nxt = w_hdr_slot ? r_shift : (r_shift >> 8);
      w_cnt_nxt   = r_cnt + 1'b1;
      w_accept    = r_tx_valid & i_tx_ready;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_cnt       <= '0;
         r_res_ready <= 1'b0;
         r_tx_data   <= 8'h00;
         r_tx_valid  <= 1'b0;
         r_tx_last   <= 1'b0;
         r_frame_cnt <= 8'h00;
      end else begin
         if (r_res_ready && !i_res_valid) begin
            r_res_ready <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               if (i_res_valid && !r_res_ready) begin
                  r_shift     <= w_pad;
                  r_res_ready <= 1'b1;
                  r_cnt       <= '0;
                  r_tx_valid  <= 1'b1;
                  r_tx_last   <= (TOTAL == 1);
                  r_tx_data   <= (HDR_EN != 0) ? HEADER : w_pad[7:0];
                  r_state     <= StSend;
               end
            end
            StSend: begin
               if (w_accept) begin
                  if (r_cnt == LastCnt) begin
                     r_tx_valid  <= 1'b0;
                     r_tx_last   <= 1'b0;
                     r_frame_cnt <= r_frame_cnt + 8'd1;
                     r_state     <= StDrain;
                  end else begin
                     r_shift   <= w_shift_nxt;
                     r_cnt     <= w_cnt_nxt;
                     r_tx_data <= w_shift_nxt[7:0];
                     r_tx_last <= (w_cnt_nxt == LastCnt);
                  end
               end
            end
            StDrain: begin
               // A core still holding res_valid parks us here: no re-capture.
               if (!r_res_ready && !i_res_valid) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_res_ready = r_res_ready;
   assign o_tx_data   = r_tx_data;
   assign o_tx_valid  = r_tx_valid;
   assign o_tx_last   = r_tx_last;
   assign o_busy      = (r_state != StIdle);
   assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_result_byte_tx.sv
// Scoreboard bench for result_byte_tx: default build plus a headerless single-word build.
module tb_result_byte_tx;

   logic         clk = 1'b0;
   logic         rstn;
   logic [509:0] din;
   logic         res_valid;
   logic         res_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready = 1'b1;
   logic         tx_last;
   logic         busy;
   logic [7:0]   frame_cnt;

   logic [254:0] din2;
   logic         rv2;
   logic         rr2;
   logic [7:0]   td2;
   logic         tv2;
   logic         tr2 = 1'b1;
   logic         tl2;
   logic         busy2;
   logic [7:0]   fc2;

   int errors = 0;
   int checks = 0;
   int acc1   = 0;
   int acc2   = 0;
   int tr_mode = 0;
   int pi     = 0;
   logic [7:0] exp_fc = 8'd0;

   logic [8:0] q1[$];
   logic [8:0] q2[$];

   always #5 clk = ~clk;

   result_byte_tx dut (
      .i_clk(clk), .i_rstn(rstn), .i_din(din), .i_res_valid(res_valid),
      .o_res_ready(res_ready), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
      .i_tx_ready(tx_ready), .o_tx_last(tx_last), .o_busy(busy), .o_frame_cnt(frame_cnt)
   );

   result_byte_tx #(.N(255), .NWORDS(1), .HDR_EN(0), .HEADER(8'hA5)) dut2 (
      .i_clk(clk), .i_rstn(rstn), .i_din(din2), .i_res_valid(rv2),
      .o_res_ready(rr2), .o_tx_data(td2), .o_tx_valid(tv2),
      .i_tx_ready(tr2), .o_tx_last(tl2), .o_busy(busy2), .o_frame_cnt(fc2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Header, one chosen byte, 62 zero bytes, then a chosen final byte.
   task automatic push_std(input logic [7:0] b0, input logic [7:0] blast);
      q1.push_back({1'b0, 8'hA5});
      q1.push_back({1'b0, b0});
      for (int i = 0; i < 62; i++) q1.push_back({1'b0, 8'h00});
      q1.push_back({1'b1, blast});
   endtask

   always @(posedge clk) begin
      #1;
      if (tr_mode == 0) tx_ready = 1'b1;
      else begin
         tx_ready = ((pi % 4) == 0) || ((pi % 4) == 3);
         pi++;
      end
   end

   logic       p_valid = 1'b0;
   logic       p_ready = 1'b0;
   logic [7:0] p_data  = 8'h00;
   logic       p_last  = 1'b0;

   always @(negedge clk) begin
      logic [8:0] e;
      if (rstn && p_valid && !p_ready && tx_valid) begin
         chk("hold_data", {24'd0, tx_data}, {24'd0, p_data});
         chk("hold_last", {31'd0, tx_last}, {31'd0, p_last});
      end
      if (rstn && tx_valid && tx_ready) begin
         acc1++;
         if (q1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", tx_data);
         end else begin
            e = q1.pop_front();
            chk("byte_data", {24'd0, tx_data}, {24'd0, e[7:0]});
            chk("byte_last", {31'd0, tx_last}, {31'd0, e[8]});
         end
      end
      p_valid = rstn && tx_valid;
      p_ready = tx_ready;
      p_data  = tx_data;
      p_last  = tx_last;
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (rstn && tv2 && tr2) begin
         acc2++;
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte2: got %0h expected none", td2);
         end else begin
            e = q2.pop_front();
            chk("byte2_data", {24'd0, td2}, {24'd0, e[7:0]});
            chk("byte2_last", {31'd0, tl2}, {31'd0, e[8]});
         end
      end
   end

   task automatic wait_idle(input int lim, input string name);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, lim);
      end
   endtask

   // Core side of the return-to-zero handshake with its timing checks.
   task automatic start_frame(input logic [509:0] d);
      @(posedge clk); #1;
      din = d;
      res_valid = 1'b1;
      @(negedge clk);
      chk("rr_pre", {31'd0, res_ready}, 32'd0);
      @(negedge clk);
      chk("rr_rise", {31'd0, res_ready}, 32'd1);
      chk("txv_rise", {31'd0, tx_valid}, 32'd1);
      @(posedge clk); #1;
      res_valid = 1'b0;
      @(negedge clk);
      chk("rr_hold", {31'd0, res_ready}, 32'd1);
      @(negedge clk);
      chk("rr_fall", {31'd0, res_ready}, 32'd0);
   endtask

   task automatic end_frame(input string name);
      wait_idle(3000, name);
      exp_fc = exp_fc + 8'd1;
      chk({name, "_fc"}, {24'd0, frame_cnt}, {24'd0, exp_fc});
      chk({name, "_qempty"}, q1.size(), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [509:0] d;
      int n;
      int bad;
      rstn = 1'b0;
      res_valid = 1'b0;
      din = '0;
      rv2 = 1'b0;
      din2 = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      chk("rst_txv", {31'd0, tx_valid}, 32'd0);
      chk("rst_rr", {31'd0, res_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fc", {24'd0, frame_cnt}, 32'd0);
      chk("rst_txd", {24'd0, tx_data}, 32'd0);
      chk("rst_last", {31'd0, tx_last}, 32'd0);

      // Headerless single word: 2^255-19
      q2.push_back({1'b0, 8'hED});
      for (int i = 0; i < 30; i++) q2.push_back({1'b0, 8'hFF});
      q2.push_back({1'b1, 8'h7F});
      @(posedge clk); #1;
      din2 = {255{1'b1}} - 255'd18;
      rv2 = 1'b1;
      n = 0;
      while (!rr2 && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1 rv2 = 1'b0;
      n = 0;
      while ((busy2 || rr2) && n < 200) begin @(negedge clk); n++; end
      chk("d2_busy", {31'd0, busy2}, 32'd0);
      chk("d2_fc", {24'd0, fc2}, 32'd1);
      chk("d2_count", acc2, 32'd32);
      chk("d2_qempty", q2.size(), 32'd0);

      // Frame 1: word0=1, word1=2^254
      d = '0;
      d[0] = 1'b1;
      d[255 + 254] = 1'b1;
      push_std(8'h01, 8'h40);
      start_frame(d);
      end_frame("f1");

      // Same frame under 1,0,0,1 backpressure
      tr_mode = 1;
      push_std(8'h01, 8'h40);
      start_frame(d);
      end_frame("f2_bp");
      tr_mode = 0;

      // res_valid held long past frame end
      d = '0;
      d[7:0] = 8'h33;
      push_std(8'h33, 8'h00);
      @(posedge clk); #1;
      din = d;
      res_valid = 1'b1;
      n = 0;
      while (frame_cnt != exp_fc + 8'd1 && n < 2000) begin @(negedge clk); n++; end
      exp_fc = exp_fc + 8'd1;
      chk("drain_fc", {24'd0, frame_cnt}, {24'd0, exp_fc});
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_valid || !busy || !res_ready) bad++;
      end
      chk("drain_hold", bad, 32'd0);
      @(posedge clk); #1 res_valid = 1'b0;
      @(negedge clk);
      wait_idle(5, "drain_exit");
      chk("drain_qempty", q1.size(), 32'd0);
      push_std(8'h44, 8'h00);
      d[7:0] = 8'h44;
      start_frame(d);
      end_frame("f_after_drain");

      // Reset mid-frame after byte 10
      d[7:0] = 8'h5A;
      push_std(8'h5A, 8'h00);
      n = acc1;
      start_frame(d);
      bad = 0;
      while (acc1 < n + 10 && bad < 200) begin @(negedge clk); bad++; end
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      q1.delete();
      exp_fc = 8'd0;
      @(negedge clk);
      chk("mid_rst_txv", {31'd0, tx_valid}, 32'd0);
      chk("mid_rst_rr", {31'd0, res_ready}, 32'd0);
      chk("mid_rst_fc", {24'd0, frame_cnt}, 32'd0);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (tx_valid || busy) bad++;
      end
      chk("mid_rst_quiet", bad, 32'd0);
      push_std(8'h5A, 8'h00);
      start_frame(d);
      end_frame("f_after_rst");

      // Fill out to 256 frames: frame_cnt wraps to 0
      for (int f = 0; f < 255; f++) begin
         d = '0;
         d[7:0] = 8'(f);
         push_std(8'(f), 8'h00);
         start_frame(d);
         end_frame("wrap");
      end
      chk("wrap_zero", {24'd0, frame_cnt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
